// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite subsystem: loader FSM states, pixel packing
// helper and the slot-address width used by both the loader and the sprite read side.
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNPACK = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

    localparam int SPRITE_SLOTS = 4;
    localparam int SLOT_AW      = $clog2(SPRITE_SLOTS);

    // Pixels packed into one byte for a given colour depth.
    function automatic int ppb(input int colr_bits);
        return 8 / colr_bits;
    endfunction

endpackage

// File: rtl/sprite_loader.sv
// Unpacks a valid/ready byte stream into COLR_BITS pixels and writes them into one
// image slot of the shared sprite pixel memory, only while vblank is high.
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int COLR_BITS = 4,
    parameter int ADDRW     = 6,
    parameter int SLOTS     = SPRITE_SLOTS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(SLOTS)-1:0]         slot,
    input  logic                             vblank,
    input  logic [7:0]                       in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             mem_we,
    output logic [$clog2(SLOTS)+ADDRW-1:0]   mem_addr,
    output logic [COLR_BITS-1:0]             mem_data,
    output logic                             busy,
    output logic                             done
);

    localparam int SW   = $clog2(SLOTS);
    localparam int PPB  = ppb(COLR_BITS);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int SUBW = (PPB > 1) ? $clog2(PPB) : 1;
    localparam logic [ADDRW-1:0] LAST_PIX = ADDRW'(NPIX - 1);
    localparam logic [SUBW-1:0]  LAST_SUB = SUBW'(PPB - 1);

    loader_state_t   state_r, state_s;
    logic [SW-1:0]   slot_r, slot_s;
    logic [ADDRW-1:0] pix_r, pix_s;
    logic [SUBW-1:0] sub_r, sub_s;
    logic [7:0]      byte_r, byte_s;

    // Next-state and output decode; vblank is the only input reaching the outputs.
    always_comb begin
        state_s  = state_r;
        slot_s   = slot_r;
        pix_s    = pix_r;
        sub_s    = sub_r;
        byte_s   = byte_r;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {slot_r, pix_r};
        mem_data = byte_r[int'(sub_r) * COLR_BITS +: COLR_BITS];
        busy     = (state_r != ST_IDLE);
        done     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pix_s = {ADDRW{1'b0}};
                sub_s = {SUBW{1'b0}};
                if (start) begin
                    slot_s  = slot;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                in_ready = vblank;
                if (in_valid && vblank) begin
                    byte_s  = in_data;
                    sub_s   = {SUBW{1'b0}};
                    state_s = ST_UNPACK;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_UNPACK: begin
                if (vblank) begin
                    mem_we = 1'b1;
                    pix_s  = pix_r + ADDRW'(1);
                    sub_s  = sub_r + SUBW'(1);
                    // Terminal check on the pixel count, not on address wrap.
                    if (pix_r == LAST_PIX) begin
                        state_s = ST_DONE;
                    end else if (sub_r == LAST_SUB) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_UNPACK;
                    end
                end else begin
                    state_s = ST_UNPACK;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            slot_r  <= {SW{1'b0}};
            pix_r   <= {ADDRW{1'b0}};
            sub_r   <= {SUBW{1'b0}};
            byte_r  <= 8'h00;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
            pix_r   <= pix_s;
            sub_r   <= sub_s;
            byte_r  <= byte_s;
        end
    end

endmodule
